// File: rtl/ps_loader.sv
// ps_loader: passive-serial bitstream shifter with CONF_DONE/nSTATUS monitoring and init clocks
module ps_loader #(
  parameter int CLK_DIV = 1,
  parameter int INIT_CLOCKS = 3200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       dclk,
  output logic       data0,
  input  logic       n_status,
  input  logic       conf_done,
  output logic       busy,
  output logic       done,
  output logic       error
);
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int NW = $clog2(INIT_CLOCKS + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, INIT, DONE, ERROR} state_t;
  state_t state;
  logic [7:0] sr;
  logic last;
  logic [2:0] bit_idx;
  logic [PW-1:0] ph;
  logic [NW-1:0] pulses;
  logic ph_end;
  logic active;
  assign ph_end = ph == PW'(CLK_DIV - 1);
  assign active = state == LOAD || state == SHIFT || state == INIT;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      last <= 1'b0;
      bit_idx <= '0;
      ph <= '0;
      pulses <= '0;
      dclk <= 1'b0;
      data0 <= 1'b0;
      byte_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else if (active && !n_status) begin
      state <= ERROR;
      dclk <= 1'b0;
      byte_ready <= 1'b0;
      busy <= 1'b0;
      error <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state <= LOAD;
            byte_ready <= 1'b1;
            busy <= 1'b1;
            done <= 1'b0;
            error <= 1'b0;
            dclk <= 1'b0;
          end
        end
        LOAD: begin
          if (byte_valid) begin
            state <= SHIFT;
            sr <= byte_data;
            last <= byte_last;
            data0 <= byte_data[0];
            bit_idx <= '0;
            ph <= '0;
            byte_ready <= 1'b0;
          end
        end
        SHIFT: begin
          if (!ph_end) ph <= ph + 1'b1;
          else begin
            ph <= '0;
            if (!dclk) dclk <= 1'b1;
            else begin
              dclk <= 1'b0;
              if (bit_idx != 3'd7) begin
                bit_idx <= bit_idx + 3'd1;
                sr <= sr >> 1;
                data0 <= sr[1];
              end else if (conf_done) begin
                state <= INIT;
                data0 <= 1'b0;
                pulses <= '0;
              end else if (last) begin
                state <= ERROR;
                busy <= 1'b0;
                error <= 1'b1;
              end else begin
                state <= LOAD;
                byte_ready <= 1'b1;
              end
            end
          end
        end
        INIT: begin
          if (!ph_end) ph <= ph + 1'b1;
          else begin
            ph <= '0;
            if (!dclk) dclk <= 1'b1;
            else begin
              dclk <= 1'b0;
              if (pulses == NW'(INIT_CLOCKS - 1)) begin
                state <= DONE;
                busy <= 1'b0;
                done <= 1'b1;
              end else pulses <= pulses + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
